// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// classifies the opcode into a one-hot class and drives memory, register-file and PC strobes.
module rv32i_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_load,
  output logic       pc_sel,
  output logic       rf_we,
  output logic [9:0] op_code,
  output logic       instr_done,
  output logic       halted,
  output logic [1:0] trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  // Classes that write a destination register: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  localparam logic [9:0] RF_WE_MASK = 10'b01_1010_1111;

  state_t     state_r, state_s;
  logic [9:0] op_code_r, op_code_s;
  logic [1:0] trap_cause_r, trap_cause_s;
  logic [7:0] tmo_cnt_r, tmo_cnt_s;
  logic       req_s, we_s, addr_sel_s, ir_load_s, pc_load_s, pc_sel_s, rf_we_s, done_s, halted_s;

  function automatic logic [9:0] classify(input logic [6:0] opc);
    logic [9:0] cls;
    case (opc)
      7'b0110111: cls = 10'b00_0000_0001;
      7'b0010111: cls = 10'b00_0000_0010;
      7'b1101111: cls = 10'b00_0000_0100;
      7'b1100111: cls = 10'b00_0000_1000;
      7'b1100011: cls = 10'b00_0001_0000;
      7'b0000011: cls = 10'b00_0010_0000;
      7'b0100011: cls = 10'b00_0100_0000;
      7'b0010011: cls = 10'b00_1000_0000;
      7'b0110011: cls = 10'b01_0000_0000;
      7'b1110011: cls = 10'b10_0000_0000;
      default:    cls = 10'b00_0000_0000;
    endcase
    return cls;
  endfunction

  // FENCE is legal but has no class bit; it flows through as a NOP.
  function automatic logic is_legal(input logic [6:0] opc);
    return (classify(opc) != 10'b00_0000_0000) || (opc == 7'b0001111);
  endfunction

  // Next-state, timeout counter and decoded strobes.
  always_comb begin
    state_s      = state_r;
    op_code_s    = op_code_r;
    trap_cause_s = trap_cause_r;
    tmo_cnt_s    = tmo_cnt_r;
    req_s        = 1'b0;
    we_s         = 1'b0;
    addr_sel_s   = 1'b0;
    ir_load_s    = 1'b0;
    pc_load_s    = 1'b0;
    pc_sel_s     = 1'b0;
    rf_we_s      = 1'b0;
    done_s       = 1'b0;
    halted_s     = 1'b0;
    case (state_r)
      S_FETCH, S_MEM: begin
        req_s      = 1'b1;
        addr_sel_s = (state_r == S_MEM);
        we_s       = (state_r == S_MEM) & op_code_r[6];
        ir_load_s  = (state_r == S_FETCH) & mem_ready;
        // Completion wins over a timeout expiring in the same cycle.
        if (mem_ready) begin
          state_s   = (state_r == S_FETCH) ? S_DECODE : S_WRITEBACK;
          tmo_cnt_s = 8'd0;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s      = S_TRAP;
          trap_cause_s = 2'b10;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 8'd1;
        end
      end
      S_DECODE: begin
        op_code_s = classify(opcode);
        if (is_legal(opcode)) begin
          state_s = S_EXECUTE;
        end else begin
          state_s      = S_TRAP;
          trap_cause_s = 2'b01;
        end
      end
      S_EXECUTE: begin
        tmo_cnt_s = 8'd0;
        if (op_code_r[9]) begin
          state_s      = S_TRAP;
          trap_cause_s = 2'b11;
        end else if (op_code_r[5] | op_code_r[6]) begin
          state_s = S_MEM;
        end else begin
          state_s = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        pc_load_s = 1'b1;
        done_s    = 1'b1;
        rf_we_s   = |(op_code_r & RF_WE_MASK);
        pc_sel_s  = op_code_r[2] | op_code_r[3] | (op_code_r[4] & branch_taken);
        tmo_cnt_s = 8'd0;
        state_s   = S_FETCH;
      end
      S_TRAP: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // State, class, trap cause and timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_FETCH;
      op_code_r    <= 10'b00_0000_0000;
      trap_cause_r <= 2'b00;
      tmo_cnt_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      op_code_r    <= op_code_s;
      trap_cause_r <= trap_cause_s;
      tmo_cnt_r    <= tmo_cnt_s;
    end
  end

  // Every output is forced low while reset is held, whatever state the FSM was in.
  assign mem_req      = req_s & ~reset;
  assign mem_we       = we_s & ~reset;
  assign mem_addr_sel = addr_sel_s & ~reset;
  assign ir_load      = ir_load_s & ~reset;
  assign pc_load      = pc_load_s & ~reset;
  assign pc_sel       = pc_sel_s & ~reset;
  assign rf_we        = rf_we_s & ~reset;
  assign instr_done   = done_s & ~reset;
  assign halted       = halted_s & ~reset;
  assign op_code      = reset ? 10'b00_0000_0000 : op_code_r;
  assign trap_cause   = reset ? 2'b00 : trap_cause_r;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: expected retirements are queued when an
// instruction is driven and compared when instr_done pulses.
module tb_rv32i_multicycle_ctrl;

  localparam int TO = 16;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_SYS = 7'b1110011, OPC_FENCE = 7'b0001111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, rf_we;
  logic [9:0] op_code;
  logic       instr_done, halted;
  logic [1:0] trap_cause;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0] op;
    logic       rf_we;
    logic       pc_sel;
    int         lat;
    int         start;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  rv32i_multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .rf_we(rf_we), .op_code(op_code),
    .instr_done(instr_done), .halted(halted), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] outs();
    return {mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, rf_we,
            op_code, instr_done, halted, trap_cause};
  endfunction

  function automatic logic [9:0] cls(input logic [6:0] o);
    case (o)
      OPC_LUI:   return 10'b00_0000_0001;
      OPC_AUIPC: return 10'b00_0000_0010;
      OPC_JAL:   return 10'b00_0000_0100;
      OPC_JALR:  return 10'b00_0000_1000;
      OPC_BR:    return 10'b00_0001_0000;
      OPC_LD:    return 10'b00_0010_0000;
      OPC_ST:    return 10'b00_0100_0000;
      OPC_OPI:   return 10'b00_1000_0000;
      OPC_OP:    return 10'b01_0000_0000;
      OPC_SYS:   return 10'b10_0000_0000;
      default:   return 10'b00_0000_0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after a reset edge, in the first FETCH cycle with reset low.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    opcode = 7'd0;
    @(negedge clk);
    check_eq("rst_outs_zero", 32'(outs()), 32'd0);
    step();
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic taken, input int fw, input int mw);
    exp_t e;
    logic ls;
    ls = (opc == OPC_LD) || (opc == OPC_ST);
    e.op = cls(opc);
    e.rf_we = (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
              (opc == OPC_LD) || (opc == OPC_OPI) || (opc == OPC_OP);
    e.pc_sel = (opc == OPC_JAL) || (opc == OPC_JALR) || ((opc == OPC_BR) && taken);
    e.lat = 4 + fw + (ls ? 1 + mw : 0);
    e.start = cyc;
    exp_q.push_back(e);
    opcode = opc;
    branch_taken = taken;
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      @(negedge clk);
      check_eq("fetch_req", 32'(mem_req), 32'd1);
      check_eq("fetch_we_sel", 32'({mem_we, mem_addr_sel}), 32'd0);
      check_eq("fetch_ir_load", 32'(ir_load), 32'(mem_ready));
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("decode_req", 32'(mem_req), 32'd0);
    step();
    @(negedge clk);
    check_eq("exec_op_code", 32'(op_code), 32'(e.op));
    check_eq("exec_req", 32'(mem_req), 32'd0);
    step();
    if (ls) begin
      for (int i = 0; i <= mw; i++) begin
        mem_ready = (i == mw);
        @(negedge clk);
        check_eq("mem_req", 32'(mem_req), 32'd1);
        check_eq("mem_addr_sel", 32'(mem_addr_sel), 32'd1);
        check_eq("mem_we", 32'(mem_we), 32'(opc == OPC_ST));
        step();
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("wb_pc_load", 32'(pc_load), 32'd1);
    step();
  endtask

  // Retirement monitor: pops the scoreboard on every instr_done pulse.
  always @(negedge clk) begin
    if (!reset && instr_done) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'(instr_done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("done_op_code", 32'(op_code), 32'(mon_e.op));
        check_eq("done_rf_we", 32'(rf_we), 32'(mon_e.rf_we));
        check_eq("done_pc_sel", 32'(pc_sel), 32'(mon_e.pc_sel));
        check_eq("done_latency", 32'(cyc - mon_e.start + 1), 32'(mon_e.lat));
        check_eq("done_halted", 32'(halted), 32'd0);
      end
    end
  end

  initial begin
    logic [6:0] illegal_ops [2];
    illegal_ops[0] = 7'b0000000;
    illegal_ops[1] = 7'b0110001;

    do_reset();
    run_instr(OPC_OP, 1'b0, 0, 0);
    run_instr(OPC_OP, 1'b0, 0, 0);
    run_instr(OPC_ST, 1'b0, 0, 3);
    run_instr(OPC_BR, 1'b1, 0, 0);
    run_instr(OPC_BR, 1'b0, 0, 0);
    run_instr(OPC_LUI, 1'b0, 1, 0);
    run_instr(OPC_AUIPC, 1'b0, 0, 0);
    run_instr(OPC_JAL, 1'b0, 0, 0);
    run_instr(OPC_JALR, 1'b1, 0, 0);
    run_instr(OPC_LD, 1'b0, 2, 1);
    run_instr(OPC_OPI, 1'b1, 0, 0);
    run_instr(OPC_FENCE, 1'b0, 0, 0);

    foreach (illegal_ops[k]) begin
      do_reset();
      opcode = illegal_ops[k];
      mem_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      check_eq("ill_halted", 32'(halted), 32'd1);
      check_eq("ill_cause", 32'(trap_cause), 32'd1);
      check_eq("ill_strobes", 32'({pc_load, rf_we, instr_done, mem_req}), 32'd0);
      check_eq("ill_op_code", 32'(op_code), 32'd0);
      step();
      @(negedge clk);
      check_eq("ill_stays_halted", 32'(halted), 32'd1);
      do_reset();
      @(negedge clk);
      check_eq("post_rst_req", 32'(mem_req), 32'd1);
      check_eq("post_rst_state", 32'({op_code, halted, trap_cause}), 32'd0);
    end

    do_reset();
    opcode = OPC_OP;
    mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check_eq("tmo_wait_req", 32'({mem_req, halted}), 32'b10);
      step();
    end
    @(negedge clk);
    check_eq("tmo_halted", 32'(halted), 32'd1);
    check_eq("tmo_cause", 32'(trap_cause), 32'd2);
    check_eq("tmo_req_drop", 32'(mem_req), 32'd0);

    do_reset();
    run_instr(OPC_OP, 1'b0, TO - 1, 0);

    do_reset();
    opcode = OPC_SYS;
    mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check_eq("sys_exec_op_code", 32'(op_code), 32'(cls(OPC_SYS)));
    check_eq("sys_exec_halted", 32'(halted), 32'd0);
    step();
    @(negedge clk);
    check_eq("sys_halted", 32'(halted), 32'd1);
    check_eq("sys_cause", 32'(trap_cause), 32'd3);
    check_eq("sys_op_code_held", 32'(op_code), 32'(cls(OPC_SYS)));
    check_eq("sys_strobes", 32'({pc_load, rf_we, instr_done}), 32'd0);

    do_reset();
    opcode = OPC_LD;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("ld_in_mem", 32'({mem_req, mem_addr_sel}), 32'b11);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_eq("midmem_rst_outs", 32'(outs()), 32'd0);
    step();
    @(negedge clk);
    check_eq("midmem_next_outs", 32'(outs()), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check_eq("midmem_fetch_req", 32'({mem_req, mem_addr_sel, mem_we}), 32'b100);
    check_eq("midmem_op_code", 32'(op_code), 32'd0);

    do_reset();
    step();
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
